// File: rtl/design_2_wrapper_pkg.sv
// Shared types and defaults for the UART length/checksum echo block.
package design_2_wrapper_pkg;

  localparam int CLKS_PER_BIT_DEF = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    SEND    = 2'd2
  } ctrl_state_t;

  // One received byte, qualified by a single-cycle valid
  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rx_byte_t;

endpackage

// File: rtl/design_2_wrapper_uart_rx.sv
// 8N1 UART receiver: synchronizer, start-bit glitch filter, mid-bit sampling.
module uart_rx
  import design_2_wrapper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rxd,
  output rx_byte_t rx
);

  // CLKS_PER_BIT is expected to be >= 2 so the half-bit point is nonzero
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      st, nxt;
  logic           s1, s2, s3;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic [7:0]     shreg;
  logic           half_tick, bit_tick;

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);

  // two-flop synchronizer plus one more stage for falling-edge detection;
  // all reset to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // next-state: start on a falling edge, drop back to idle on a glitch
  always_comb begin
    nxt = st;
    case (st)
      RX_IDLE:  if (s3 && !s2) nxt = RX_START;
      RX_START: if (half_tick) nxt = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bitn == 3'd7) nxt = RX_STOP;
      RX_STOP:  if (bit_tick) nxt = RX_IDLE;
      default:  nxt = RX_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= RX_IDLE;
    else     st <= nxt;
  end

  // bit timing, shift register and the one-cycle byte strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bitn    <= '0;
      shreg   <= '0;
      rx.vld  <= 1'b0;
      rx.data <= '0;
    end else begin
      rx.vld <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt  <= '0;
          bitn <= '0;
        end
        RX_START: cnt <= half_tick ? '0 : cnt + CW'(1);
        RX_DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {s2, shreg[7:1]};
            bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            // a low stop bit is a framing error: the byte is discarded
            if (s2) begin
              rx.vld  <= 1'b1;
              rx.data <= shreg;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/design_2_wrapper.sv
// Length-prefixed message receiver: accumulates payload count/checksum on LED
// and echoes the checksum over UART once the message is complete.
module design_2_wrapper
  import design_2_wrapper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        rxd,
  output logic        txd,
  output logic [15:0] LED
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  rx_byte_t    rx;
  ctrl_state_t state, state_nxt;
  logic [7:0]  remaining, count, csum, hold_data;
  logic        hold_vld, send_loaded, tx_start, tx_busy;
  logic        in_vld;
  logic [7:0]  in_data;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_left;
  logic [CW-1:0] tx_cnt;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk (sys_clock),
    .rst (reset),
    .rxd (rxd),
    .rx  (rx)
  );

  // In IDLE a byte parked during SEND takes priority over a fresh one
  assign in_vld  = hold_vld | rx.vld;
  assign in_data = hold_vld ? hold_data : rx.data;
  assign LED     = {count, csum};

  // controller next-state and TX load strobe
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      IDLE:    if (in_vld) state_nxt = (in_data == 8'd0) ? SEND : PAYLOAD;
      PAYLOAD: if (rx.vld && remaining == 8'd1) state_nxt = SEND;
      SEND: begin
        if (!send_loaded)  tx_start  = 1'b1;
        else if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // controller state register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // length/count/checksum bookkeeping and the one-byte holding register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      remaining   <= '0;
      count       <= '0;
      csum        <= '0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
      send_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            remaining <= in_data;
            count     <= '0;
            csum      <= '0;
          end
          // held byte consumed; a coincident fresh byte takes its place
          if (hold_vld) begin
            hold_vld <= rx.vld;
            if (rx.vld) hold_data <= rx.data;
          end
        end
        PAYLOAD: begin
          if (rx.vld) begin
            csum      <= csum + rx.data;
            count     <= count + 8'd1;
            remaining <= remaining - 8'd1;
          end
        end
        SEND: begin
          if (!send_loaded)  send_loaded <= 1'b1;
          else if (!tx_busy) send_loaded <= 1'b0;
          // park one byte; further bytes while full are lost
          if (rx.vld && !hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= rx.data;
          end
        end
        default: send_loaded <= 1'b0;
      endcase
    end
  end

  // TX serializer: txd is a flop, start bit driven on load, then 8 data + stop
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_left <= '0;
      tx_cnt  <= '0;
    end else if (tx_start) begin
      txd     <= 1'b0;
      tx_sh   <= {1'b1, csum};
      tx_left <= 4'd9;
      tx_cnt  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) begin
          tx_busy <= 1'b0;
        end else begin
          txd     <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_left <= tx_left - 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_design_2_wrapper.sv
// Scoreboard bench: message-level model pushes expected echo bytes, a UART
// monitor on txd pops and compares; LED checked after each message.
module tb_design_2_wrapper;
  import design_2_wrapper_pkg::*;

  localparam int CPB = 5;

  logic        sys_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        rxd       = 1'b1;
  logic        txd;
  logic [15:0] LED;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  msg[$];
  logic [15:0] exp_led = 16'h0000;
  bit          mon_busy = 1'b0;

  design_2_wrapper #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .rxd       (rxd),
    .txd       (txd),
    .LED       (LED)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // one 8N1 frame on rxd followed by one extra idle clock
  task automatic uart_send(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
    rxd = 1'b1;
    idle(1);
  endtask

  // wait until every expected echo has been seen on txd
  task automatic wait_tx_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
      idle(1);
      t++;
    end
    if (t >= 3000) begin
      tests++;
      fails++;
      $display("FAIL tx_timeout: got %0d pending expected 0", exp_q.size());
    end
    idle(3 * CPB);
  endtask

  // reference model: msg[0] is the length, echo = sum of payload mod 256
  task automatic send_msg(input bit wait_done);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 1; i <= int'(msg[0]); i++) sum = sum + msg[i];
    exp_q.push_back(sum);
    exp_led = {msg[0], sum};
    foreach (msg[i]) uart_send(msg[i], 1'b1);
    if (wait_done) begin
      wait_tx_done();
      check("led_after_msg", 32'(LED), 32'(exp_led));
    end
  endtask

  // monitor: decode txd frames and compare with the scoreboard
  initial begin
    logic [7:0] got;
    logic       stopb;
    logic [7:0] e;
    bit         abort;
    forever begin
      @(negedge sys_clock);
      if (!reset && txd === 1'b0) begin
        mon_busy = 1'b1;
        abort    = 1'b0;
        got      = '0;
        repeat (CPB / 2) begin
          @(negedge sys_clock);
          if (reset) abort = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin
            @(negedge sys_clock);
            if (reset) abort = 1'b1;
          end
          got[i] = txd;
        end
        repeat (CPB) begin
          @(negedge sys_clock);
          if (reset) abort = 1'b1;
        end
        stopb = txd;
        if (abort) begin
          exp_q.delete();
        end else if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got frame %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {23'd0, stopb, got}, {23'd0, 1'b1, e});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int t;
    int n;
    idle(5);
    check("reset_led", 32'(LED), 32'h0);
    check("reset_txd", 32'(txd), 32'h1);
    reset = 1'b0;
    idle(5);

    // length 3, payload 1,2,3 -> 0x0306, echo 0x06
    msg.delete();
    msg.push_back(8'h03); msg.push_back(8'h01); msg.push_back(8'h02); msg.push_back(8'h03);
    send_msg(1'b1);
    check("led_0306", 32'(LED), 32'h0306);

    // empty message -> echo 0x00, FSM idle
    msg.delete();
    msg.push_back(8'h00);
    send_msg(1'b1);
    check("led_0000", 32'(LED), 32'h0000);
    check("fsm_idle", 32'(dut.state), 32'(IDLE));

    // checksum wraps
    msg.delete();
    msg.push_back(8'h02); msg.push_back(8'hFF); msg.push_back(8'h02);
    send_msg(1'b1);
    check("led_0201", 32'(LED), 32'h0201);

    // framing error: byte dropped, nothing sent
    uart_send(8'h01, 1'b0);
    idle(12 * CPB);
    check("led_framing", 32'(LED), 32'h0201);

    // 2-cycle glitch on idle line
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(12 * CPB);
    check("led_glitch", 32'(LED), 32'h0201);
    check("queue_glitch", 32'(exp_q.size()), 32'h0);

    // back-to-back messages: second length byte lands while echoing the first
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'hAA);
    send_msg(1'b0);
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h55);
    send_msg(1'b1);

    // randomized messages
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 6);
      msg.delete();
      msg.push_back(8'(n));
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(1'b1);
    end

    // reset while the echo is on the wire
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h5A);
    send_msg(1'b0);
    t = 0;
    while (!mon_busy && t < 2000) begin
      idle(1);
      t++;
    end
    check("tx_started", 32'(mon_busy), 32'h1);
    check("led_before_rst", 32'(LED), 32'h015A);
    idle(2 * CPB);
    reset = 1'b1;
    #1;
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_led", 32'(LED), 32'h0);
    idle(4);
    reset = 1'b0;
    t = 0;
    while (mon_busy && t < 2000) begin
      idle(1);
      t++;
    end
    idle(5);

    // RX recovers after reset
    msg.delete();
    msg.push_back(8'h02); msg.push_back(8'h10); msg.push_back(8'h20);
    send_msg(1'b1);
    check("led_after_rst", 32'(LED), 32'h0230);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/design_2_wrapper.md
DESIGN_2_WRAPPER -- requirements
Module: design_2_wrapper

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5: sys_clock cycles per UART bit, 8N1 framing, LSB first.
REQ-002 SHALL have port sys_clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rxd, input, 1 bit: UART receive line, idle high.
REQ-005 SHALL have port txd, output, 1 bit: UART transmit line, idle high.
REQ-006 SHALL have port LED, output, 16 bits: LED[15:8] = payload byte count, LED[7:0] = running 8-bit checksum.

Function
REQ-007 SHALL double-flop rxd into the sys_clock domain before any use.
REQ-008 RX: a falling edge in idle starts a frame; SHALL re-check the line low at CLKS_PER_BIT/2 (integer) cycles, else return to idle (glitch).
REQ-009 RX SHALL sample data bits 0..7, then the stop bit, every CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-010 RX SHALL emit a one-cycle rx_valid pulse with the byte when the stop bit samples 1; stop bit 0 SHALL drop the byte (framing error) and return to idle.
REQ-011 RX SHALL accept a new start bit immediately after the stop-bit sample.
REQ-012 Controller FSM states: IDLE, PAYLOAD, SEND.
REQ-013 IDLE + rx_valid: latch byte as remaining length N, clear count and checksum; N>0 -> PAYLOAD, N==0 -> SEND.
REQ-014 PAYLOAD + rx_valid: checksum += byte (mod 256), count += 1 (mod 256), remaining -= 1; remaining reaching 0 -> SEND.
REQ-015 SEND: load checksum into TX on the cycle after entry, then return to IDLE when TX is idle again.
REQ-016 TX SHALL send start bit 0, 8 data bits LSB first, and stop bit 1, each CLKS_PER_BIT cycles; txd SHALL be 1 when idle.
REQ-017 A byte received during SEND SHALL be held in a 1-byte holding register and processed on return to IDLE; a second byte while the register is full SHALL be dropped.
REQ-018 LED SHALL update on the cycle after rx_valid and SHALL keep its value through SEND until the next length byte clears it.
REQ-019 txd SHALL be registered (no combinational path from rxd to txd).

Reset
REQ-020 Reset asserted: txd=1, LED=0, FSM=IDLE, RX/TX idle, counters and holding register cleared, asynchronously.
REQ-021 Reset mid-frame SHALL abort RX and TX; after release, the first falling edge on rxd starts a new frame.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the CLKS_PER_BIT default constant.
REQ-023 The UART receiver SHALL be one sub-module, uart_rx; TX serializer and controller stay in design_2_wrapper.

Verification
REQ-024 Reset, then frames 0x03, 0x01, 0x02, 0x03 at 5 clk/bit with 1 extra idle clock between frames -> LED=16'h0306; txd sends 0x06 (start, 0,1,1,0,0,0,0,0, stop) starting within 3 clocks of the last stop-bit sample.
REQ-025 Frame 0x00 -> LED=16'h0000; txd sends 0x00 frame; FSM back in IDLE.
REQ-026 Frame 0x02, then 0xFF, 0x02 -> checksum wraps, LED=16'h0201; txd sends 0x01.
REQ-027 Frame with stop bit 0 -> LED unchanged; no txd activity.
REQ-028 2-cycle low glitch on idle rxd -> no byte received; LED unchanged.
REQ-029 Reset asserted mid-TX -> txd=1 within the same cycle, LED=0.
